// File: rtl/multi_port_fifo_flopped.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multi_port_fifo_flopped
// Brief    : Flop-based FIFO with PUSH_NUM write lanes and POP_NUM read lanes
//            per cycle, all-or-nothing group acceptance and sticky error flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module multi_port_fifo_flopped #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 16,
    parameter int PUSH_NUM  = 2,
    parameter int POP_NUM   = 2,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [PUSH_NUM-1:0]           push,
    input  logic [PUSH_NUM*DWIDTH-1:0]    push_data,
    input  logic [POP_NUM-1:0]            pop,
    output logic [POP_NUM*DWIDTH-1:0]     pop_data,
    output logic [POP_NUM-1:0]            pop_valid,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [$clog2(DEPTH+1)-1:0]    free_slots,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int            c_cw     = $clog2(DEPTH + 1);
    localparam int            c_pw     = $clog2(DEPTH);
    localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
    localparam logic [c_cw:0]   c_depth_x = (c_cw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_afull  = c_cw'(AFULL_TH);
    localparam logic [c_cw-1:0] c_aempty = c_cw'(AEMPTY_TH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              r_ovf;
    logic              r_udf;

    logic [c_cw-1:0]   w_push_cnt;
    logic [c_cw-1:0]   w_pop_cnt;
    logic              w_push_bad;
    logic              w_pop_bad;
    logic              w_push_gap;
    logic              w_pop_gap;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [c_cw-1:0]   w_push_acc;
    logic [c_cw-1:0]   w_pop_acc;
    logic [c_cw-1:0]   w_free;

    // Pointer + offset modulo DEPTH; offset never exceeds DEPTH so one subtract suffices.
    function automatic logic [c_pw-1:0] ptr_add(input logic [c_pw-1:0] p, input logic [c_cw-1:0] k);
        logic [c_cw:0] s;
        s = {{(c_cw + 1 - c_pw){1'b0}}, p} + {1'b0, k};
        if (s >= c_depth_x) begin
            s = s - c_depth_x;
        end
        return s[c_pw-1:0];
    endfunction

    // Lane counts stop at the first clear bit; any set bit beyond it is a protocol error.
    always_comb begin
        w_push_cnt = '0;
        w_push_gap = 1'b0;
        w_push_bad = 1'b0;
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (push[i]) begin
                if (w_push_gap) begin
                    w_push_bad = 1'b1;
                end else begin
                    w_push_cnt = w_push_cnt + c_cw'(1);
                end
            end else begin
                w_push_gap = 1'b1;
            end
        end
    end

    always_comb begin
        w_pop_cnt = '0;
        w_pop_gap = 1'b0;
        w_pop_bad = 1'b0;
        for (int i = 0; i < POP_NUM; i++) begin
            if (pop[i]) begin
                if (w_pop_gap) begin
                    w_pop_bad = 1'b1;
                end else begin
                    w_pop_cnt = w_pop_cnt + c_cw'(1);
                end
            end else begin
                w_pop_gap = 1'b1;
            end
        end
    end

    assign w_free     = c_depth - r_count;
    assign w_push_ok  = (w_push_cnt <= w_free);
    assign w_pop_ok   = (w_pop_cnt <= r_count);
    assign w_push_acc = (w_push_ok && !flush) ? w_push_cnt : '0;
    assign w_pop_acc  = (w_pop_ok && !flush) ? w_pop_cnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= ptr_add(r_wr_ptr, w_push_acc);
            r_rd_ptr <= ptr_add(r_rd_ptr, w_pop_acc);
            r_count  <= r_count + w_push_acc - w_pop_acc;
            if (w_push_bad || !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_bad || !w_pop_ok) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (c_cw'(i) < w_push_acc) begin
                r_mem[ptr_add(r_wr_ptr, c_cw'(i))] <= push_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    for (genvar i = 0; i < POP_NUM; i++) begin : g_pop_lane
        assign pop_data[i*DWIDTH +: DWIDTH] = r_mem[ptr_add(r_rd_ptr, c_cw'(i))];
        assign pop_valid[i]                 = (c_cw'(i) < r_count);
    end

    assign count         = r_count;
    assign free_slots    = w_free;
    assign full          = (r_count == c_depth);
    assign empty         = (r_count == '0);
    assign almost_full   = (r_count >= c_afull);
    assign almost_empty  = (r_count <= c_aempty);
    assign overflow_err  = r_ovf;
    assign underflow_err = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_multi_port_fifo_flopped.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_multi_port_fifo_flopped
// Brief    : Directed vector table plus hand sequences for wrap, flush and reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_multi_port_fifo_flopped;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  push;
    logic [15:0] push_data;
    logic [1:0]  pop;
    logic [15:0] pop_data;
    logic [1:0]  pop_valid;
    logic [2:0]  count;
    logic [2:0]  free_slots;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow_err;
    logic        underflow_err;

    int checks   = 0;
    int failures = 0;

    multi_port_fifo_flopped #(
        .DWIDTH   (8),
        .DEPTH    (6),
        .PUSH_NUM (2),
        .POP_NUM  (2),
        .AFULL_TH (4),
        .AEMPTY_TH(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .count        (count),
        .free_slots   (free_slots),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       fl;
        logic [1:0] pu;
        logic [7:0] d1;
        logic [7:0] d0;
        logic [1:0] po;
        logic [2:0] cnt;
        logic [1:0] vld;
        logic [7:0] q0;
        logic [7:0] q1;
        logic [3:0] flg;   // {full, empty, almost_full, almost_empty}
        logic       oe;
        logic       ue;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic fl, input logic [1:0] pu, input logic [7:0] d1,
                                input logic [7:0] d0, input logic [1:0] po, input logic [2:0] cnt,
                                input logic [1:0] vld, input logic [7:0] q0, input logic [7:0] q1,
                                input logic [3:0] flg, input logic oe, input logic ue);
        vec_t v;
        v.fl = fl; v.pu = pu; v.d1 = d1; v.d0 = d0; v.po = po; v.cnt = cnt;
        v.vld = vld; v.q0 = q0; v.q1 = q1; v.flg = flg; v.oe = oe; v.ue = ue;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic [1:0] pu, input logic [7:0] d1,
                         input logic [7:0] d0, input logic [1:0] po);
        flush     = fl;
        push      = pu;
        push_data = {d1, d0};
        pop       = po;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_free"}, 32'(free_slots), 32'd6);
        chk({tag, "_flags"}, 32'({full, empty, almost_full, almost_empty}), 32'b0101);
        chk({tag, "_valid"}, 32'(pop_valid), 32'd0);
    endtask

    logic [7:0] q[$];
    logic [7:0] v;

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_errs", 32'({overflow_err, underflow_err}), 32'd0);

        //           fl  push   d1     d0     pop    cnt   vld    q0     q1     flags   oe    ue
        vecs[0]  = mk(0, 2'b11, 8'hA1, 8'hA0, 2'b00, 3'd2, 2'b11, 8'hA0, 8'hA1, 4'b0000, 1'b0, 1'b0);
        vecs[1]  = mk(0, 2'b01, 8'h00, 8'hB0, 2'b00, 3'd3, 2'b11, 8'hA0, 8'hA1, 4'b0000, 1'b0, 1'b0);
        vecs[2]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b01, 3'd2, 2'b11, 8'hA1, 8'hB0, 4'b0000, 1'b0, 1'b0);
        vecs[3]  = mk(0, 2'b11, 8'hC1, 8'hC0, 2'b11, 3'd2, 2'b11, 8'hC0, 8'hC1, 4'b0000, 1'b0, 1'b0);
        vecs[4]  = mk(0, 2'b11, 8'hD1, 8'hD0, 2'b00, 3'd4, 2'b11, 8'hC0, 8'hC1, 4'b0010, 1'b0, 1'b0);
        vecs[5]  = mk(0, 2'b01, 8'h00, 8'hE0, 2'b00, 3'd5, 2'b11, 8'hC0, 8'hC1, 4'b0010, 1'b0, 1'b0);
        vecs[6]  = mk(0, 2'b11, 8'hF1, 8'hF0, 2'b00, 3'd5, 2'b11, 8'hC0, 8'hC1, 4'b0010, 1'b1, 1'b0);
        vecs[7]  = mk(0, 2'b01, 8'h00, 8'h60, 2'b11, 3'd4, 2'b11, 8'hD0, 8'hD1, 4'b0010, 1'b1, 1'b0);
        vecs[8]  = mk(0, 2'b11, 8'h71, 8'h70, 2'b00, 3'd6, 2'b11, 8'hD0, 8'hD1, 4'b1010, 1'b1, 1'b0);
        vecs[9]  = mk(0, 2'b01, 8'h00, 8'h80, 2'b11, 3'd4, 2'b11, 8'hE0, 8'h60, 4'b0010, 1'b1, 1'b0);
        vecs[10] = mk(1, 2'b11, 8'h55, 8'h55, 2'b11, 3'd0, 2'b00, 8'h00, 8'h00, 4'b0101, 1'b1, 1'b0);
        vecs[11] = mk(0, 2'b01, 8'h00, 8'h90, 2'b00, 3'd1, 2'b01, 8'h90, 8'h00, 4'b0001, 1'b1, 1'b0);
        vecs[12] = mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 3'd1, 2'b01, 8'h90, 8'h00, 4'b0001, 1'b1, 1'b1);
        vecs[13] = mk(0, 2'b00, 8'h00, 8'h00, 2'b01, 3'd0, 2'b00, 8'h00, 8'h00, 4'b0101, 1'b1, 1'b1);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].fl, vecs[i].pu, vecs[i].d1, vecs[i].d0, vecs[i].po);
            step();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_free", i), 32'(free_slots), 32'(3'd6 - vecs[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(pop_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_flags", i), 32'({full, empty, almost_full, almost_empty}), 32'(vecs[i].flg));
            chk($sformatf("v%0d_ovf", i), 32'(overflow_err), 32'(vecs[i].oe));
            chk($sformatf("v%0d_udf", i), 32'(underflow_err), 32'(vecs[i].ue));
            if (vecs[i].vld[0]) chk($sformatf("v%0d_lane0", i), 32'(pop_data[7:0]), 32'(vecs[i].q0));
            if (vecs[i].vld[1]) chk($sformatf("v%0d_lane1", i), 32'(pop_data[15:8]), 32'(vecs[i].q1));
        end

        // Reset clears sticky errors; then non-contiguous lane patterns set them.
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst2");
        chk("rst2_errs", 32'({overflow_err, underflow_err}), 32'd0);
        drive(1'b0, 2'b10, 8'h11, 8'h00, 2'b00);
        step();
        chk("gap_push_count", 32'(count), 32'd0);
        chk("gap_push_errs", 32'({overflow_err, underflow_err}), 32'b10);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b10);
        step();
        chk("gap_pop_errs", 32'({overflow_err, underflow_err}), 32'b11);

        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Streaming at count 2 with rd_ptr odd so lane pairs straddle index 5 -> 0.
        v = 8'h10;
        drive(1'b0, 2'b01, 8'h00, v, 2'b00);
        q.push_back(v);
        v++;
        step();
        drive(1'b0, 2'b11, v + 8'd1, v, 2'b00);
        q.push_back(v);
        q.push_back(v + 8'd1);
        v += 8'd2;
        step();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        step();
        void'(q.pop_front());
        chk("wrap_start_count", 32'(count), 32'd2);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("wrap%0d_lane0", c), 32'(pop_data[7:0]), 32'(q[0]));
            chk($sformatf("wrap%0d_lane1", c), 32'(pop_data[15:8]), 32'(q[1]));
            drive(1'b0, 2'b11, v + 8'd1, v, 2'b11);
            q.push_back(v);
            q.push_back(v + 8'd1);
            v += 8'd2;
            step();
            void'(q.pop_front());
            void'(q.pop_front());
            chk($sformatf("wrap%0d_count", c), 32'(count), 32'd2);
        end
        chk("wrap_end_lane0", 32'(pop_data[7:0]), 32'(q[0]));
        chk("wrap_end_errs", 32'({overflow_err, underflow_err}), 32'd0);

        // Flush at count 4 with a push pending: everything discarded, no error.
        drive(1'b0, 2'b11, 8'h22, 8'h21, 2'b00);
        step();
        chk("pre_flush_count", 32'(count), 32'd4);
        drive(1'b1, 2'b11, 8'h24, 8'h23, 2'b00);
        step();
        chk_idle("flush");
        chk("flush_errs", 32'({overflow_err, underflow_err}), 32'd0);

        // Asynchronous reset mid-cycle at count 3 with a push in flight.
        drive(1'b0, 2'b11, 8'h32, 8'h31, 2'b00);
        step();
        drive(1'b0, 2'b01, 8'h00, 8'h33, 2'b00);
        step();
        chk("pre_rst_count", 32'(count), 32'd3);
        drive(1'b0, 2'b11, 8'h35, 8'h34, 2'b00);
        #3;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        chk("rst_held_count", 32'(count), 32'd0);
        step();
        chk_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
